// File: rtl/mest_pro_mem_ctrl_pkg.sv
// Shared widths, memory map and op-type encoding for the MESTPro memory initiator.
package mest_pro_mem_ctrl_pkg;

    localparam int unsigned ADDR_BITS        = 16;
    localparam int unsigned DATA_BITS        = 16;
    localparam int unsigned INSTRUCTION_SIZE = 16;
    localparam int unsigned ROM_SIZE         = 256;

    // Op type latched at grant; reused by the core.
    typedef enum logic [1:0] {
        OP_FETCH = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } mem_op_e;

    // Map a data-port write enable onto its op type.
    function automatic mem_op_e data_op(input logic we);
        return we ? OP_STORE : OP_LOAD;
    endfunction

endpackage

// File: rtl/mest_pro_mem_ctrl_arb.sv
// Fetch/data priority with a bounded data streak so fetches cannot starve.
module mest_pro_mem_arb
    import mest_pro_mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_STREAK = 3
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic i_fetch_req,
    input  logic i_data_req,
    input  logic i_grant_en,
    output logic o_grant_fetch_c,
    output logic o_grant_data_c
);

    localparam int unsigned CNT_W = $clog2(DATA_STREAK + 2);

    logic [CNT_W-1:0] r_streak;
    logic             w_streak_full;
    logic             w_fetch_first;

    assign w_streak_full   = (r_streak == CNT_W'(DATA_STREAK));
    assign w_fetch_first   = i_fetch_req && (!i_data_req || w_streak_full);
    assign o_grant_fetch_c = i_grant_en && w_fetch_first;
    assign o_grant_data_c  = i_grant_en && i_data_req && !w_fetch_first;

    // Count data grants that overtook a waiting fetch; any other grant clears it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_streak <= '0;
        end else if (o_grant_fetch_c) begin
            r_streak <= '0;
        end else if (o_grant_data_c) begin
            if (!i_fetch_req) begin
                r_streak <= '0;
            end else if (!w_streak_full) begin
                r_streak <= r_streak + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mest_pro_mem_ctrl.sv
// Serialises fetch and load/store requests onto the single-port memory command bus.
module mest_pro_mem_ctrl
    import mest_pro_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_BITS,
    parameter int unsigned DATA_W      = DATA_BITS,
    parameter int unsigned INST_W      = INSTRUCTION_SIZE,
    parameter int unsigned DATA_STREAK = 3
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_fetch_pc,
    output logic              o_fetch_ack,
    output logic [INST_W-1:0] o_inst,
    input  logic              i_data_req,
    input  logic              i_data_we,
    input  logic [ADDR_W-1:0] i_data_addr,
    input  logic [DATA_W-1:0] i_data_wdata,
    output logic              o_data_ack,
    output logic [INST_W-1:0] o_data_rdata,
    output logic              o_data_err,
    output logic              o_mem_cs,
    output logic              o_mem_we,
    output logic              o_mem_sel,
    output logic [ADDR_W-1:0] o_mem_pc,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdat,
    input  logic [INST_W-1:0] i_mem_inst,
    input  logic [INST_W-1:0] i_mem_dat,
    input  logic              i_mem_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e  r_state;
    mem_op_e r_op;
    logic    w_grant_en;
    logic    w_grant_fetch;
    logic    w_grant_data;

    assign w_grant_en = (r_state == ST_IDLE);

    mest_pro_mem_arb #(
        .DATA_STREAK (DATA_STREAK)
    ) u_arb (
        .CLK             (CLK),
        .RESET_N         (RESET_N),
        .i_fetch_req     (i_fetch_req),
        .i_data_req      (i_data_req),
        .i_grant_en      (w_grant_en),
        .o_grant_fetch_c (w_grant_fetch),
        .o_grant_data_c  (w_grant_data)
    );

    // Access sequencer: grant in IDLE, one command cycle, capture, one-cycle ack.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_FETCH;
            o_fetch_ack  <= 1'b0;
            o_inst       <= '0;
            o_data_ack   <= 1'b0;
            o_data_rdata <= '0;
            o_data_err   <= 1'b0;
            o_mem_cs     <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_sel    <= 1'b0;
            o_mem_pc     <= '0;
            o_mem_addr   <= '0;
            o_mem_wdat   <= '0;
        end else begin
            o_fetch_ack <= 1'b0;
            o_data_ack  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_fetch) begin
                        r_op     <= OP_FETCH;
                        o_mem_cs <= 1'b1;
                        o_mem_pc <= i_fetch_pc;
                        r_state  <= ST_ISSUE;
                    end else if (w_grant_data) begin
                        r_op       <= data_op(i_data_we);
                        o_mem_we   <= i_data_we;
                        o_mem_sel  <= !i_data_we;
                        o_mem_addr <= i_data_addr;
                        if (i_data_we) begin
                            o_mem_wdat <= i_data_wdata;
                        end
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    o_mem_cs  <= 1'b0;
                    o_mem_we  <= 1'b0;
                    o_mem_sel <= 1'b0;
                    r_state   <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    case (r_op)
                        OP_FETCH: begin
                            o_inst      <= i_mem_inst;
                            o_fetch_ack <= 1'b1;
                        end
                        OP_LOAD: begin
                            o_data_rdata <= i_mem_dat;
                            o_data_err   <= i_mem_err;
                            o_data_ack   <= 1'b1;
                        end
                        default: begin
                            o_data_err <= i_mem_err;
                            o_data_ack <= 1'b1;
                        end
                    endcase
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mest_pro_mem_ctrl.sv
// Bench for mest_pro_mem_ctrl: behavioural memory, transaction-level reference, directed + random accesses.
module tb_mest_pro_mem_ctrl;
    import mest_pro_mem_ctrl_pkg::*;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned IW    = 16;
    localparam int unsigned DEPTH = 1024;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          i_fetch_req;
    logic [AW-1:0] i_fetch_pc;
    logic          o_fetch_ack;
    logic [IW-1:0] o_inst;
    logic          i_data_req;
    logic          i_data_we;
    logic [AW-1:0] i_data_addr;
    logic [DW-1:0] i_data_wdata;
    logic          o_data_ack;
    logic [IW-1:0] o_data_rdata;
    logic          o_data_err;
    logic          o_mem_cs;
    logic          o_mem_we;
    logic          o_mem_sel;
    logic [AW-1:0] o_mem_pc;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdat;
    logic [IW-1:0] m_inst;
    logic [IW-1:0] m_dat;
    logic          m_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected results, maintained at the transaction level.
    logic [15:0] ref_mem [DEPTH];
    logic [15:0] exp_inst;
    logic [15:0] exp_rdata;
    logic        exp_err;

    mest_pro_mem_ctrl #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .INST_W      (IW),
        .DATA_STREAK (3)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .i_fetch_req  (i_fetch_req),
        .i_fetch_pc   (i_fetch_pc),
        .o_fetch_ack  (o_fetch_ack),
        .o_inst       (o_inst),
        .i_data_req   (i_data_req),
        .i_data_we    (i_data_we),
        .i_data_addr  (i_data_addr),
        .i_data_wdata (i_data_wdata),
        .o_data_ack   (o_data_ack),
        .o_data_rdata (o_data_rdata),
        .o_data_err   (o_data_err),
        .o_mem_cs     (o_mem_cs),
        .o_mem_we     (o_mem_we),
        .o_mem_sel    (o_mem_sel),
        .o_mem_pc     (o_mem_pc),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdat   (o_mem_wdat),
        .i_mem_inst   (m_inst),
        .i_mem_dat    (m_dat),
        .i_mem_err    (m_err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] init_word(input int i);
        if (i == 5) return 16'h1234;
        return 16'((i * 40503) ^ 23130);
    endfunction

    // Behavioural single-port memory with registered outputs and ROM write protection.
    logic [15:0] mem [DEPTH];
    bit          init_done = 1'b0;
    always @(posedge CLK) begin
        if (!init_done) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= init_word(i);
            m_inst    <= '0;
            m_dat     <= '0;
            m_err     <= 1'b0;
            init_done <= 1'b1;
        end else if (o_mem_cs) begin
            m_inst <= mem[o_mem_pc[9:0]];
            m_err  <= 1'($urandom);
        end else if (o_mem_sel && !o_mem_we) begin
            m_dat <= mem[o_mem_addr[9:0]];
            m_err <= 1'b0;
        end else if (o_mem_we) begin
            if (int'(o_mem_addr) < int'(ROM_SIZE)) begin
                m_err <= 1'b1;
            end else begin
                mem[o_mem_addr[9:0]] <= o_mem_wdat;
                m_err <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, 32'({o_fetch_ack, o_data_ack, o_data_err, o_mem_cs, o_mem_we, o_mem_sel}), 32'd0);
        check({tag, "_inst"},  32'(o_inst), 32'd0);
        check({tag, "_rdata"}, 32'(o_data_rdata), 32'd0);
        check({tag, "_pc"},    32'(o_mem_pc), 32'd0);
        check({tag, "_addr"},  32'(o_mem_addr), 32'd0);
        check({tag, "_wdat"},  32'(o_mem_wdat), 32'd0);
    endtask

    // One access from an idle controller; checks command cycle, latency and result.
    task automatic do_access(input mem_op_e op, input logic [15:0] addr, input logic [15:0] wd);
        int cyc;
        bit got;
        logic [2:0] exp_cmd;
        if (op == OP_FETCH) begin
            i_fetch_req = 1'b1;
            i_fetch_pc  = addr;
            exp_cmd     = 3'b100;
        end else begin
            i_data_req   = 1'b1;
            i_data_we    = (op == OP_STORE);
            i_data_addr  = addr;
            i_data_wdata = wd;
            exp_cmd      = (op == OP_STORE) ? 3'b010 : 3'b001;
        end
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 10) begin
            @(posedge CLK); #1;
            cyc++;
            if (cyc == 1) begin
                check("issue_cmd", 32'({o_mem_cs, o_mem_we, o_mem_sel}), 32'(exp_cmd));
                if (op == OP_FETCH) check("issue_pc", 32'(o_mem_pc), 32'(addr));
                else check("issue_addr", 32'(o_mem_addr), 32'(addr));
                if (op == OP_STORE) check("issue_wdat", 32'(o_mem_wdat), 32'(wd));
            end
            if (cyc == 2) check("capture_cmd", 32'({o_mem_cs, o_mem_we, o_mem_sel}), 32'd0);
            got = (op == OP_FETCH) ? o_fetch_ack : o_data_ack;
        end
        check("latency", 32'(cyc), 32'd3);
        case (op)
            OP_FETCH: begin
                exp_inst = ref_mem[addr[9:0]];
                check("fetch_inst", 32'(o_inst), 32'(exp_inst));
                check("fetch_err_hold", 32'(o_data_err), 32'(exp_err));
            end
            OP_LOAD: begin
                exp_rdata = ref_mem[addr[9:0]];
                exp_err   = 1'b0;
                check("load_rdata", 32'(o_data_rdata), 32'(exp_rdata));
                check("load_err", 32'(o_data_err), 32'(exp_err));
            end
            default: begin
                exp_err = (int'(addr) < int'(ROM_SIZE));
                if (!exp_err) ref_mem[addr[9:0]] = wd;
                check("store_err", 32'(o_data_err), 32'(exp_err));
                check("store_rdata_hold", 32'(o_data_rdata), 32'(exp_rdata));
            end
        endcase
        i_fetch_req = 1'b0;
        i_data_req  = 1'b0;
        @(posedge CLK); #1;
        check("ack_pulse", 32'({o_fetch_ack, o_data_ack}), 32'd0);
    endtask

    initial begin
        string seq;
        int    nd;
        int    nf;
        int    cyc;
        mem_op_e rop;

        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);
        exp_inst  = '0;
        exp_rdata = '0;
        exp_err   = 1'b0;
        RESET_N      = 1'b0;
        i_fetch_req  = 1'b0;
        i_fetch_pc   = '0;
        i_data_req   = 1'b0;
        i_data_we    = 1'b0;
        i_data_addr  = '0;
        i_data_wdata = '0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        // Step 1: fetch of pc 5.
        do_access(OP_FETCH, 16'd5, 16'd0);
        check("fetch5_value", 32'(o_inst), 32'h1234);

        // Step 2: RAM store then load-back.
        do_access(OP_STORE, 16'(ROM_SIZE + 2), 16'hBEEF);
        do_access(OP_LOAD,  16'(ROM_SIZE + 2), 16'd0);
        check("ram_readback", 32'(o_data_rdata), 32'hBEEF);

        // Step 3: ROM store is refused, following ROM load is clean.
        do_access(OP_STORE, 16'd0, 16'hDEAD);
        do_access(OP_LOAD,  16'd1, 16'd0);

        // Step 4: concurrent fetch and data streams exercise the streak limit.
        seq = "";
        nd  = 0;
        nf  = 0;
        cyc = 0;
        i_fetch_pc   = 16'd9;
        i_data_we    = 1'b0;
        i_data_addr  = 16'd300;
        i_fetch_req  = 1'b1;
        i_data_req   = 1'b1;
        while ((nd < 5 || nf < 2) && cyc < 80) begin
            @(posedge CLK); #1;
            cyc++;
            if (o_data_ack) begin
                seq = {seq, "D"};
                nd++;
                if (nd == 5) i_data_req = 1'b0;
            end
            if (o_fetch_ack) begin
                seq = {seq, "F"};
                nf++;
                if (nf == 2) i_fetch_req = 1'b0;
            end
        end
        n_tests++;
        assert (seq == "DDDFDDF") else begin
            n_fail++;
            $error("FAIL grant_order: observed %s expected DDDFDDF", seq);
        end
        exp_inst  = ref_mem[9];
        exp_rdata = ref_mem[300];
        exp_err   = 1'b0;
        check("order_inst", 32'(o_inst), 32'(exp_inst));
        check("order_rdata", 32'(o_data_rdata), 32'(exp_rdata));
        @(posedge CLK); #1;

        // Step 5: reset in the CAPTURE cycle of a load.
        i_data_req  = 1'b1;
        i_data_we   = 1'b0;
        i_data_addr = 16'd301;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET_N    = 1'b0;
        i_data_req = 1'b0;
        #1;
        check_all_zero("mid_reset");
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            check("reset_no_ack", 32'({o_fetch_ack, o_data_ack}), 32'd0);
        end
        RESET_N   = 1'b1;
        exp_inst  = '0;
        exp_rdata = '0;
        exp_err   = 1'b0;
        do_access(OP_FETCH, 16'd7, 16'd0);

        // Step 6: random mix of fetches, loads and stores across ROM and RAM.
        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 2))
                0:       rop = OP_FETCH;
                1:       rop = OP_LOAD;
                default: rop = OP_STORE;
            endcase
            do_access(rop, 16'($urandom_range(0, 511)), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
